regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised register file for the next-generation pipelined processor. It provides two read ports, a main write-back port and a dedicated link-register write port for JL. It also adds a per-register pending-write scoreboard that raises a stall for load-use hazards, and a registered debug readout port driven by inr/out_value. The block sits between the decode stage (reads, stall) and the write-back stage (writes, scoreboard clear).

Parameters:
DataWidth, 16, width of each register and data port
RegAddrBits, 3, register address width
TotalReg, 8, number of registers; must equal 2**RegAddrBits
ZeroReg, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary
LinkReg, 7, register index written by the link port
Bypass, 1, 1 = same-cycle write-to-read forwarding; 0 = reads see only committed state

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  asynchronous active-high reset
ra1  input  RegAddrBits  read address, port 1
ra2  input  RegAddrBits  read address, port 2
use1  input  1  decode actually consumes rd1 (stall qualifier)
use2  input  1  decode actually consumes rd2 (stall qualifier)
rd1  output  DataWidth  read data, port 1 (combinational)
rd2  output  DataWidth  read data, port 2 (combinational)
wen  input  1  main write enable
waddr  input  RegAddrBits  main write address
wdata  input  DataWidth  main write data
lwen  input  1  link write enable (writes LinkReg)
ldata  input  DataWidth  link data (return PC)
sb_set  input  1  mark sb_addr as pending (load issued)
sb_addr  input  RegAddrBits  scoreboard set address
stall  output  1  hazard stall to decode (combinational)
busy_vec  output  TotalReg  registered scoreboard bits, bit i = register i pending
inr  input  RegAddrBits  debug register select
out_value  output  DataWidth  debug register value (registered)

Behaviour:
- Reset: RST high asynchronously clears all registers, busy_vec and out_value to 0. While RST is high: rd1/rd2 = 0 and stall = 0. Writes and sb_set are ignored. Reset mid-operation discards pending scoreboard bits.
- Writes commit on the rising CLK edge.
- Main write and link write both target LinkReg in the same cycle: the main port wins and the link data is dropped.
- Writes from either port to register 0 are discarded when ZeroReg=1.
- Read: rd = regs[ra]; forced to 0 for ra=0 when ZeroReg=1.
- Bypass=1 forwarding: if wen and waddr==ra (and the write is not discarded), rd = wdata. Else if lwen and ra==LinkReg, rd = ldata. Priority for forwarding is the same as for writes.
- Scoreboard clear: a committed write (either port) to register r clears busy[r] at the edge.
- Scoreboard set: sb_set sets busy[sb_addr] at the edge. The write to sb_addr is ignored when ZeroReg=1 and sb_addr=0.
- Set and clear of the same register in one cycle: set wins, so busy stays 1 (new pending load).
- stall = (use1 & busy[ra1] & ~fwd1) | (use2 & busy[ra2] & ~fwd2).
  - fwdN is 1 when the port-N data is being forwarded this cycle (Bypass=1 only). A write-back arriving therefore releases the stall in the same cycle.
  - With Bypass=0, the stall releases one cycle after the write commits.
- Debug: out_value <= regs[inr] at each edge, giving one-cycle latency. It shows the committed value only, with no bypass. out_value = 0 for inr=0 when ZeroReg=1.
- Address wrap: all addresses are exactly RegAddrBits wide, so no out-of-range case exists.

Test Plan:
1. Reset, then write R2=4, R3=1 -> after two edges, inr=2 gives out_value=0004 one cycle later; inr=3 gives 0001. All other registers read 0000.
2. Zero register: wen, waddr=0, wdata=FFFF; sb_set with sb_addr=0 -> rd1 for ra1=0 stays 0000 and busy_vec[0] stays 0.
3. Bypass: wen, waddr=4, wdata=0005 with ra1=4 in the same cycle -> rd1=0005 before the edge. Repeat with Bypass=0 -> rd1 = old value 0000.
4. Load-use: sb_set, sb_addr=5; next cycle ra2=5, use2=1 -> stall=1. With use2=0 -> stall=0. When the write to R5 (0x00AA) arrives -> stall=0 that cycle and busy_vec[5]=0 after the edge.
5. Link conflict: lwen with ldata=0x0012 alone -> R7=0012. Then lwen with ldata=0x0034 and wen, waddr=7, wdata=0x0099 together -> R7=0099. Also: sb_set and write to the same register in one cycle -> busy bit remains 1.
6. Async reset mid-operation: with busy_vec=0x28 and R2=0003, pulse RST between clock edges -> busy_vec, out_value, R2 and stall become 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with a load-use scoreboard and a registered debug port.
// Sits between decode (reads, stall) and write-back (writes, scoreboard clear).
module regfile_scoreboard #(
  parameter int DataWidth   = 16,
  parameter int RegAddrBits = 3,
  parameter int TotalReg    = 8,
  parameter int ZeroReg     = 1,
  parameter int LinkReg     = 7,
  parameter int Bypass      = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [RegAddrBits-1:0] ra1,
  input  logic [RegAddrBits-1:0] ra2,
  input  logic                   use1,
  input  logic                   use2,
  output logic [DataWidth-1:0]   rd1,
  output logic [DataWidth-1:0]   rd2,
  input  logic                   wen,
  input  logic [RegAddrBits-1:0] waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic                   lwen,
  input  logic [DataWidth-1:0]   ldata,
  input  logic                   sb_set,
  input  logic [RegAddrBits-1:0] sb_addr,
  output logic                   stall,
  output logic [TotalReg-1:0]    busy_vec,
  input  logic [RegAddrBits-1:0] inr,
  output logic [DataWidth-1:0]   out_value
);

  localparam logic [RegAddrBits-1:0] LinkAddr = RegAddrBits'(LinkReg);
  localparam bit HasZero   = (ZeroReg != 0);
  localparam bit HasBypass = (Bypass != 0);

  logic [DataWidth-1:0] regs [TotalReg];
  logic [TotalReg-1:0]  busy;
  logic [TotalReg-1:0]  busyNext;
  logic                 mainOk;
  logic                 linkOk;
  logic                 setOk;
  logic                 fwd1;
  logic                 fwd2;

  // Main port beats the link port when both aim at the link register.
  assign mainOk = wen && !(HasZero && (waddr == '0));
  assign linkOk = lwen && !(HasZero && (LinkAddr == '0)) && !(mainOk && (waddr == LinkAddr));
  assign setOk  = sb_set && !(HasZero && (sb_addr == '0));

  assign fwd1 = HasBypass && ((mainOk && (waddr == ra1)) || (linkOk && (ra1 == LinkAddr)));
  assign fwd2 = HasBypass && ((mainOk && (waddr == ra2)) || (linkOk && (ra2 == LinkAddr)));

  always_comb begin
    rd1 = regs[ra1];
    if (HasBypass && mainOk && (waddr == ra1))
      rd1 = wdata;
    else if (HasBypass && linkOk && (ra1 == LinkAddr))
      rd1 = ldata;
    if (RST || (HasZero && (ra1 == '0)))
      rd1 = '0;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (HasBypass && mainOk && (waddr == ra2))
      rd2 = wdata;
    else if (HasBypass && linkOk && (ra2 == LinkAddr))
      rd2 = ldata;
    if (RST || (HasZero && (ra2 == '0)))
      rd2 = '0;
  end

  // Clear on committed write first, then set, so a new pending load wins.
  always_comb begin
    busyNext = busy;
    if (mainOk)
      busyNext[waddr] = 1'b0;
    if (linkOk)
      busyNext[LinkAddr] = 1'b0;
    if (setOk)
      busyNext[sb_addr] = 1'b1;
  end

  assign stall = !RST && ((use1 && busy[ra1] && !fwd1) || (use2 && busy[ra2] && !fwd2));
  assign busy_vec = busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TotalReg; i++)
        regs[i] <= '0;
      busy      <= '0;
      out_value <= '0;
    end else begin
      if (mainOk)
        regs[waddr] <= wdata;
      if (linkOk)
        regs[LinkAddr] <= ldata;
      busy      <= busyNext;
      out_value <= (HasZero && (inr == '0)) ? '0 : regs[inr];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing instance and one non-bypassing
// instance share all inputs so forwarding and stall timing can be compared side by side.
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  ra1, ra2, waddr, sb_addr, inr;
  logic        use1, use2, wen, lwen, sb_set;
  logic [15:0] wdata, ldata;

  logic [15:0] rd1, rd2, outValue;
  logic        stall;
  logic [7:0]  busyVec;
  logic [15:0] rd1Nb, rd2Nb, outValueNb;
  logic        stallNb;
  logic [7:0]  busyVecNb;

  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  regfile_scoreboard #(.Bypass(1)) dut (
    .CLK(CLK), .RST(RST), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
    .rd1(rd1), .rd2(rd2), .wen(wen), .waddr(waddr), .wdata(wdata),
    .lwen(lwen), .ldata(ldata), .sb_set(sb_set), .sb_addr(sb_addr),
    .stall(stall), .busy_vec(busyVec), .inr(inr), .out_value(outValue)
  );

  regfile_scoreboard #(.Bypass(0)) dutNb (
    .CLK(CLK), .RST(RST), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
    .rd1(rd1Nb), .rd2(rd2Nb), .wen(wen), .waddr(waddr), .wdata(wdata),
    .lwen(lwen), .ldata(ldata), .sb_set(sb_set), .sb_addr(sb_addr),
    .stall(stallNb), .busy_vec(busyVecNb), .inr(inr), .out_value(outValueNb)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wen = 0; lwen = 0; sb_set = 0; use1 = 0; use2 = 0;
  endtask

  initial begin
    RST = 1; idle();
    ra1 = 0; ra2 = 0; waddr = 0; sb_addr = 0; inr = 0; wdata = 0; ldata = 0;
    #2;
    checkVal("rst_rd1", rd1, 16'h0000);
    checkVal("rst_stall", stall, 0);
    checkVal("rst_busy", busyVec, 8'h00);
    checkVal("rst_out", outValue, 16'h0000);
    #10 RST = 0;

    // 1: basic writes and debug readout
    tick();
    wen = 1; waddr = 2; wdata = 16'h0004;
    tick();
    waddr = 3; wdata = 16'h0001;
    tick();
    wen = 0; inr = 2;
    tick();
    checkVal("dbg_r2", outValue, 16'h0004);
    inr = 3;
    tick();
    checkVal("dbg_r3", outValue, 16'h0001);
    checkVal("dbg_r3_nb", outValueNb, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      if (i != 2 && i != 3) begin
        ra1 = 3'(i);
        #1 checkVal($sformatf("zero_r%0d", i), rd1, 16'h0000);
      end
    end
    checkVal("busy_idle", busyVec, 8'h00);

    // 2: zero register
    ra1 = 0; wen = 1; waddr = 0; wdata = 16'hFFFF; sb_set = 1; sb_addr = 0;
    #1 checkVal("r0_fwd", rd1, 16'h0000);
    tick();
    idle(); inr = 0;
    #1 checkVal("r0_rd", rd1, 16'h0000);
    checkVal("r0_busy", busyVec, 8'h00);
    tick();
    checkVal("r0_dbg", outValue, 16'h0000);

    // 3: bypass vs committed-only read
    ra1 = 4; wen = 1; waddr = 4; wdata = 16'h0005;
    #1 checkVal("byp_rd1", rd1, 16'h0005);
    checkVal("nobyp_rd1", rd1Nb, 16'h0000);
    tick();
    wen = 0;
    #1 checkVal("nobyp_commit", rd1Nb, 16'h0005);

    // 4: load-use hazard
    sb_set = 1; sb_addr = 5;
    tick();
    sb_set = 0;
    checkVal("lu_busy", busyVec, 8'h20);
    ra2 = 5; use2 = 1;
    #1 checkVal("lu_stall", stall, 1);
    checkVal("lu_stall_nb", stallNb, 1);
    use2 = 0;
    #1 checkVal("lu_nouse", stall, 0);
    use2 = 1; wen = 1; waddr = 5; wdata = 16'h00AA;
    #1 checkVal("lu_release", stall, 0);
    checkVal("lu_release_nb", stallNb, 1);
    checkVal("lu_rd2", rd2, 16'h00AA);
    tick();
    wen = 0;
    #1 checkVal("lu_busy_clr", busyVec, 8'h00);
    checkVal("lu_nb_after", stallNb, 0);
    checkVal("lu_nb_rd2", rd2Nb, 16'h00AA);
    use2 = 0;

    // 5: link port and conflicts
    ra1 = 7; lwen = 1; ldata = 16'h0012;
    #1 checkVal("lnk_fwd", rd1, 16'h0012);
    checkVal("lnk_fwd_nb", rd1Nb, 16'h0000);
    tick();
    lwen = 0;
    #1 checkVal("lnk_commit", rd1, 16'h0012);
    lwen = 1; ldata = 16'h0034; wen = 1; waddr = 7; wdata = 16'h0099;
    #1 checkVal("lnk_conf_fwd", rd1, 16'h0099);
    tick();
    idle();
    #1 checkVal("lnk_conf", rd1, 16'h0099);
    checkVal("lnk_conf_nb", rd1Nb, 16'h0099);
    sb_set = 1; sb_addr = 6; wen = 1; waddr = 6; wdata = 16'h0066;
    tick();
    idle();
    checkVal("set_wins", busyVec, 8'h40);
    wen = 1; waddr = 6;
    tick();
    idle();
    checkVal("clr_r6", busyVec, 8'h00);

    // 6: async reset mid-operation
    sb_set = 1; sb_addr = 3; wen = 1; waddr = 2; wdata = 16'h0003;
    tick();
    idle(); sb_set = 1; sb_addr = 5;
    tick();
    idle(); inr = 2;
    tick();
    checkVal("pre_busy", busyVec, 8'h28);
    checkVal("pre_out", outValue, 16'h0003);
    ra1 = 2; ra2 = 3; use2 = 1;
    #1 checkVal("pre_stall", stall, 1);
    checkVal("pre_rd1", rd1, 16'h0003);
    RST = 1;
    #1 checkVal("ar_busy", busyVec, 8'h00);
    checkVal("ar_out", outValue, 16'h0000);
    checkVal("ar_stall", stall, 0);
    checkVal("ar_rd1", rd1, 16'h0000);
    RST = 0;
    #1 checkVal("ar_r2", rd1, 16'h0000);
    checkVal("ar_stall_after", stall, 0);
    checkVal("ar_busy_after", busyVec, 8'h00);
    use2 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
